// File: rtl/led_pkg.sv
// Shared widths and grant encoding for the LED channel memory path.
package led_pkg;

   localparam int LED_ADDR_W       = 13;
   localparam int LED_DATA_W       = 8;
   localparam int CHANNELS_PER_LED = 3;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_RD,
      GNT_WR0,
      GNT_WR1
   } grant_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. The pointer names the preferred requester
// and flips to the other one after every grant.
module rr_arb2 (
   input  logic       clk_16mhz,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic rr_ptr_q;
   logic rr_ptr_d;

   always_comb begin
      gnt      = 2'b00;
      rr_ptr_d = rr_ptr_q;
      if (en) begin
         if (req[rr_ptr_q]) begin
            gnt[rr_ptr_q] = 1'b1;
         end else if (req[!rr_ptr_q]) begin
            gnt[!rr_ptr_q] = 1'b1;
         end
      end
      if (gnt[0]) begin
         rr_ptr_d = 1'b1;
      end else if (gnt[1]) begin
         rr_ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_16mhz) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/led_mem_arbiter.sv
// Arbitrates one read client and two write clients onto the single-port LED
// channel RAM: reads first, bounded write starvation, round-robin writers.
module led_mem_arbiter
   import led_pkg::*;
#(
   parameter int NUM_LEDS     = 3,
   parameter int NUM_CHANNELS = NUM_LEDS * CHANNELS_PER_LED,
   parameter int ADDR_W       = LED_ADDR_W,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk_16mhz,
   input  logic                  rst,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic                  rd_data_valid,
   output logic [LED_DATA_W-1:0] rd_data,
   input  logic [1:0]            wr_valid,
   output logic [1:0]            wr_ready,
   input  logic [ADDR_W-1:0]     wr_addr0,
   input  logic [ADDR_W-1:0]     wr_addr1,
   input  logic [LED_DATA_W-1:0] wr_data0,
   input  logic [LED_DATA_W-1:0] wr_data1,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic                  ram_we,
   output logic [LED_DATA_W-1:0] ram_wdata,
   input  logic [LED_DATA_W-1:0] ram_rdata,
   output logic                  starve_evt
);

   localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(NUM_CHANNELS);

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_pend_q, rd_pend_d;
   logic              oor_q, oor_d;

   logic       any_wr;
   logic       force_wr;
   logic       rd_win;
   logic       arb_en;
   logic [1:0] wr_gnt;
   grant_t     grant;

   assign any_wr   = |wr_valid;
   assign force_wr = (starve_cnt_q == LIMIT_C) && any_wr;
   assign rd_win   = !rst && rd_valid && !force_wr;
   assign arb_en   = !rst && !rd_win;

   rr_arb2 u_rr_arb2 (
      .clk_16mhz (clk_16mhz),
      .rst       (rst),
      .req       (wr_valid),
      .en        (arb_en),
      .gnt       (wr_gnt)
   );

   always_comb begin
      grant = GNT_NONE;
      if (rd_win) begin
         grant = GNT_RD;
      end else if (wr_gnt[0]) begin
         grant = GNT_WR0;
      end else if (wr_gnt[1]) begin
         grant = GNT_WR1;
      end
   end

   assign rd_ready   = (grant == GNT_RD);
   assign wr_ready   = wr_gnt;
   assign starve_evt = force_wr && (wr_gnt != 2'b00);

   // Out-of-range writes are still handshaken but never reach the RAM.
   always_comb begin
      ram_addr  = addr_q;
      ram_wdata = wr_data0;
      ram_we    = 1'b0;
      case (grant)
         GNT_RD: begin
            ram_addr = rd_addr;
         end
         GNT_WR0: begin
            ram_addr  = wr_addr0;
            ram_wdata = wr_data0;
            ram_we    = (wr_addr0 < DEPTH_C);
         end
         GNT_WR1: begin
            ram_addr  = wr_addr1;
            ram_wdata = wr_data1;
            ram_we    = (wr_addr1 < DEPTH_C);
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if ((wr_gnt != 2'b00) || !any_wr) begin
         starve_cnt_d = '0;
      end else if (rd_win && (starve_cnt_q != LIMIT_C)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   assign rd_pend_d = rd_win;
   assign oor_d     = rd_win && (rd_addr >= DEPTH_C);

   always_ff @(posedge clk_16mhz) begin
      if (rst) begin
         starve_cnt_q <= '0;
         addr_q       <= '0;
         rd_pend_q    <= 1'b0;
         oor_q        <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= ram_addr;
         rd_pend_q    <= rd_pend_d;
         oor_q        <= oor_d;
      end
   end

   // Gating with rst drops a read whose data would land in a reset cycle.
   assign rd_data_valid = rd_pend_q && !rst;
   assign rd_data       = (rd_data_valid && !oor_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_led_mem_arbiter.sv
// Scoreboard bench for led_mem_arbiter: rule-based arbitration model plus a
// read-data queue checked by an independent monitor.
module tb_led_mem_arbiter;

   localparam int AW    = 13;
   localparam int NCH   = 9;
   localparam int LIMIT = 8;

   logic          clk_16mhz = 1'b0;
   logic          rst;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic          rd_data_valid;
   logic [7:0]    rd_data;
   logic [1:0]    wr_valid;
   logic [1:0]    wr_ready;
   logic [AW-1:0] wr_addr0, wr_addr1;
   logic [7:0]    wr_data0, wr_data1;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;
   logic          starve_evt;

   always #31 clk_16mhz = ~clk_16mhz;

   led_mem_arbiter dut (
      .clk_16mhz     (clk_16mhz),
      .rst           (rst),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_addr       (rd_addr),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr0      (wr_addr0),
      .wr_addr1      (wr_addr1),
      .wr_data0      (wr_data0),
      .wr_data1      (wr_data1),
      .ram_addr      (ram_addr),
      .ram_we        (ram_we),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata),
      .starve_evt    (starve_evt)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic preload;

   always @(posedge clk_16mhz) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [7:0] init_val(input int i);
      if (i == 2) return 8'h0f;
      if (i == 4) return 8'h11;
      return 8'(32'h30 + i);
   endfunction

   // RAM with registered read, as seen by the arbiter
   logic [7:0] mem [0:15];
   always @(posedge clk_16mhz) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      end else if (ram_we) begin
         mem[ram_addr[3:0]] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr[3:0]];
   end

   typedef struct {
      int         due;
      logic [7:0] data;
   } rd_exp_t;
   rd_exp_t sb[$];

   // Reference model: per-cycle grant from the arbitration rules
   logic [7:0] ref_mem [0:15];
   int m_cnt;
   bit m_ptr;
   always @(negedge clk_16mhz) begin
      bit         any_w, frc, e_rd, e_we;
      logic [1:0] e_wr;
      int         k;
      logic [AW-1:0] wa;
      logic [7:0] wd;
      rd_exp_t    e;
      if (preload) for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
      if (rst) begin
         chk("rst_ready", 32'({rd_ready, wr_ready}), 32'(0));
         chk("rst_we", 32'(ram_we), 32'(0));
         chk("rst_starve", 32'(starve_evt), 32'(0));
         m_cnt = 0;
         m_ptr = 1'b0;
      end else begin
         any_w = |wr_valid;
         frc   = (m_cnt == LIMIT) && any_w;
         e_rd  = rd_valid && !frc;
         e_wr  = 2'b00;
         k     = 0;
         if (!e_rd && any_w) begin
            k = wr_valid[m_ptr] ? int'(m_ptr) : int'(!m_ptr);
            e_wr[k] = 1'b1;
         end
         chk("grant", 32'({rd_ready, wr_ready}), 32'({e_rd, e_wr}));
         chk("starve_evt", 32'(starve_evt), 32'(frc && e_wr != 2'b00));
         wa   = (k == 1) ? wr_addr1 : wr_addr0;
         wd   = (k == 1) ? wr_data1 : wr_data0;
         e_we = (e_wr != 2'b00) && (int'(wa) < NCH);
         chk("ram_we", 32'(ram_we), 32'(e_we));
         if (e_we) begin
            chk("wr_addr", 32'(ram_addr), 32'(wa));
            chk("wr_data", 32'(ram_wdata), 32'(wd));
            ref_mem[wa[3:0]] = wd;
         end
         if (e_rd) begin
            chk("rd_addr", 32'(ram_addr), 32'(rd_addr));
            e.due  = cyc + 1;
            e.data = (int'(rd_addr) < NCH) ? ref_mem[rd_addr[3:0]] : 8'h00;
            sb.push_back(e);
         end
         if (e_wr != 2'b00) begin
            m_ptr = (k == 0);
            m_cnt = 0;
         end else if (!any_w) begin
            m_cnt = 0;
         end else if (e_rd && m_cnt < LIMIT) begin
            m_cnt++;
         end
      end
   end

   // Monitor: read data must appear exactly one cycle after acceptance
   always @(negedge clk_16mhz) begin
      rd_exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         if (rst) begin
            chk("rd_valid_in_rst", 32'(rd_data_valid), 32'(0));
         end else begin
            chk("rd_valid", 32'(rd_data_valid), 32'(1));
            chk("rd_data", 32'(rd_data), 32'(e.data));
            $display("read  cycle %0d data %02h expected %02h", cyc, rd_data, e.data);
         end
      end else begin
         chk("rd_valid_idle", 32'(rd_data_valid), 32'(0));
      end
      if (rst) chk("rst_rd_data", 32'(rd_data), 32'(0));
   end

   logic       acc_rd, acc_se;
   logic [1:0] acc_wr;

   task automatic tick();
      @(negedge clk_16mhz);
      acc_rd = rd_ready;
      acc_wr = wr_ready;
      acc_se = starve_evt;
      @(posedge clk_16mhz);
      #1;
   endtask

   initial begin
      int         n_rd, first, n_se;
      logic [7:0] seq;
      rst = 1'b1; preload = 1'b1;
      rd_valid = 1'b0; rd_addr = '0;
      wr_valid = 2'b00; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
      repeat (3) tick();
      preload = 1'b0; rst = 1'b0;
      repeat (2) tick();

      // simple read of RAM[2]
      rd_valid = 1'b1; rd_addr = 13'd2;
      tick();
      chk("first_rd_accept", 32'(acc_rd), 32'(1));
      rd_valid = 1'b0;
      tick();

      // both writers continuously valid: WR0, WR1, WR0, WR1
      wr_valid = 2'b11; wr_addr0 = 13'd0; wr_data0 = 8'hAA; wr_addr1 = 13'd1; wr_data1 = 8'h55;
      seq = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seq = {seq[5:0], acc_wr};
      end
      chk("alt_grants", 32'(seq), 32'(8'h66));
      wr_valid = 2'b00;
      tick();
      chk("ram0_aa", 32'(mem[0]), 32'(8'hAA));
      chk("ram1_55", 32'(mem[1]), 32'(8'h55));

      // read pressure against writer 1: forced write after 8 reads
      rd_valid = 1'b1; rd_addr = 13'd3; wr_valid = 2'b10; wr_addr1 = 13'd5; wr_data1 = 8'h77;
      n_rd = 0; first = -1; n_se = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (acc_rd && first < 0) n_rd++;
         if (acc_wr[1] && first < 0) first = i;
         if (acc_se) n_se++;
      end
      rd_valid = 1'b0; wr_valid = 2'b00;
      tick();
      chk("reads_before_force", 32'(n_rd), 32'(8));
      chk("force_cycle", 32'(first), 32'(8));
      chk("starve_pulses", 32'(n_se), 32'(2));

      // out-of-range write and read
      wr_valid = 2'b01; wr_addr0 = 13'd9; wr_data0 = 8'hFF;
      tick();
      chk("oor_wr_accept", 32'(acc_wr), 32'(2'b01));
      wr_valid = 2'b00;
      rd_valid = 1'b1; rd_addr = 13'd12;
      tick();
      chk("oor_rd_accept", 32'(acc_rd), 32'(1));
      rd_valid = 1'b0;
      tick();
      chk("oor_ram9", 32'(mem[9]), 32'(init_val(9)));

      // read and write to the same address: read wins, sees old data
      rd_valid = 1'b1; rd_addr = 13'd4; wr_valid = 2'b01; wr_addr0 = 13'd4; wr_data0 = 8'h22;
      tick();
      chk("coll_rd_first", 32'({acc_rd, acc_wr}), 32'(3'b100));
      rd_valid = 1'b0;
      tick();
      chk("coll_wr_next", 32'({acc_rd, acc_wr}), 32'(3'b001));
      wr_valid = 2'b00;
      rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      tick();
      chk("coll_ram4", 32'(mem[4]), 32'(8'h22));

      // reset right after a read acceptance; pointer returns to writer 0
      wr_valid = 2'b01; wr_addr0 = 13'd6; wr_data0 = 8'h5A;
      tick();
      wr_valid = 2'b00;
      rd_valid = 1'b1; rd_addr = 13'd2;
      tick();
      chk("pre_rst_rd_accept", 32'(acc_rd), 32'(1));
      rd_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      wr_valid = 2'b11; wr_addr0 = 13'd7; wr_data0 = 8'h3C; wr_addr1 = 13'd8; wr_data1 = 8'hC3;
      tick();
      chk("post_rst_wr0", 32'(acc_wr), 32'(2'b01));
      wr_valid = 2'b00;
      tick();

      // randomized traffic with occasional reset
      acc_rd = 1'b0; acc_wr = 2'b00;
      for (int i = 0; i < 600; i++) begin
         if (!rd_valid || acc_rd) begin
            rd_valid = ($urandom_range(0, 2) != 0);
            rd_addr  = 13'($urandom_range(0, 12));
         end
         if (!wr_valid[0] || acc_wr[0]) begin
            wr_valid[0] = ($urandom_range(0, 2) == 0);
            wr_addr0    = 13'($urandom_range(0, 10));
            wr_data0    = 8'($urandom);
         end
         if (!wr_valid[1] || acc_wr[1]) begin
            wr_valid[1] = ($urandom_range(0, 2) == 0);
            wr_addr1    = 13'($urandom_range(0, 10));
            wr_data1    = 8'($urandom);
         end
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end

      rst = 1'b0; rd_valid = 1'b0; wr_valid = 2'b00;
      repeat (3) tick();
      for (int i = 0; i < 16; i++) chk("ram_final", 32'(mem[i]), 32'(ref_mem[i]));
      chk("sb_drained", 32'(sb.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
